// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multicycle MIPS datapath
// Moore-style decode of every datapath select/enable; FETCH, MEMRD and MEMWR also look at MemReady.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  state_t state_q, state_d;

  // Asynchronous reset drops every output at once, so no partial write can follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    PCSrc     = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    InstrDone = 1'b0;
    IllegalOp = 1'b0;

    unique case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // PC+4 is computed every cycle but only committed with the instruction word.
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        state_d = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (Opcode == OP_LW || Opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (Opcode == OP_RTYPE) begin
          state_d = S_EXEC;
        end else if (Opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (Opcode == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else if (Opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        state_d   = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        PCSrc     = 2'b01;
        Branch    = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        IllegalOp = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b0;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp;
  logic       RegDst, MemtoReg, RegWrite, InstrDone, IllegalOp;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  // {MemRead,MemWrite,IorD,IRWrite,PCWrite,Branch,PCSrc,ALUSrcA,ALUSrcB,ALUOp,RegDst,MemtoReg,RegWrite,InstrDone,IllegalOp}
  logic [17:0] outv;
  assign outv = {MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA,
                 ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, InstrDone, IllegalOp};

  typedef enum {B_RST, B_FETCH, B_DECODE, B_MEMADR, B_MEMRD, B_MEMWB, B_MEMWR, B_EXEC,
                B_ALUWB, B_ADDIEX, B_ADDIWB, B_BRANCH, B_JUMP, B_ILLEGAL} bst_t;
  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [17:0] pk(input logic mrd, input logic mwr, input logic iord,
      input logic irw, input logic pcw, input logic br, input logic [1:0] pcs,
      input logic asa, input logic [1:0] asb, input logic [1:0] aop, input logic rd,
      input logic mtr, input logic rw, input logic done, input logic ill);
    return {mrd, mwr, iord, irw, pcw, br, pcs, asa, asb, aop, rd, mtr, rw, done, ill};
  endfunction

  function automatic logic [17:0] exp_out(input bst_t s, input logic mr);
    case (s)
      B_FETCH:   return pk(1, 0, 0, mr, mr, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      B_DECODE:  return pk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0);
      B_MEMADR:  return pk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
      B_MEMRD:   return pk(1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      B_MEMWB:   return pk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0);
      B_MEMWR:   return pk(0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, mr, 0);
      B_EXEC:    return pk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0);
      B_ALUWB:   return pk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 1, 0);
      B_ADDIEX:  return pk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
      B_ADDIWB:  return pk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0);
      B_BRANCH:  return pk(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 1, 0);
      B_JUMP:    return pk(0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
      B_ILLEGAL: return pk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1);
      default:   return 18'd0;
    endcase
  endfunction

  // Monitor: pops one expected vector per driven cycle; InstrDone closes a latency window.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc_cnt = 0;
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cyc_cnt++;
      check(mon_e.tag, {14'd0, outv}, {14'd0, mon_e.v});
      check({mon_e.tag, "_inv"},
            {31'd0, ($countones({RegWrite, MemWrite, PCWrite}) <= 1) && !(MemRead && MemWrite)}, 1);
      if (InstrDone) begin
        if (lat_q.size() == 0) check({mon_e.tag, "_lat_extra"}, cyc_cnt, 0);
        else check({mon_e.tag, "_lat"}, cyc_cnt, lat_q.pop_front());
        cyc_cnt = 0;
      end
    end
  end

  task automatic step(input string tag, input bst_t s, input logic mr);
    exp_t e;
    @(posedge clk);
    #1;
    MemReady = mr;
    e.tag = tag;
    e.v = exp_out(s, mr);
    exp_q.push_back(e);
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mw);
    int base;
    case (op)
      OP_LW:                            base = 5;
      OP_SW, OP_RTYPE, OP_ADDI:         base = 4;
      default:                          base = 3;
    endcase
    lat_q.push_back(base + fw + mw);
    Opcode = op;
    for (int i = 0; i < fw; i++) step(tag, B_FETCH, 1'b0);
    step(tag, B_FETCH, 1'b1);
    step(tag, B_DECODE, 1'($urandom_range(0, 1)));
    case (op)
      OP_LW: begin
        step(tag, B_MEMADR, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) step(tag, B_MEMRD, 1'b0);
        step(tag, B_MEMRD, 1'b1);
        step(tag, B_MEMWB, 1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        step(tag, B_MEMADR, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) step(tag, B_MEMWR, 1'b0);
        step(tag, B_MEMWR, 1'b1);
      end
      OP_RTYPE: begin
        step(tag, B_EXEC, 1'($urandom_range(0, 1)));
        step(tag, B_ALUWB, 1'($urandom_range(0, 1)));
      end
      OP_ADDI: begin
        step(tag, B_ADDIEX, 1'($urandom_range(0, 1)));
        step(tag, B_ADDIWB, 1'($urandom_range(0, 1)));
      end
      OP_BEQ:  step(tag, B_BRANCH, 1'($urandom_range(0, 1)));
      OP_J:    step(tag, B_JUMP, 1'($urandom_range(0, 1)));
      default: step(tag, B_ILLEGAL, 1'($urandom_range(0, 1)));
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    MemReady = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", {14'd0, outv}, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", {14'd0, outv}, 0);

    run_instr("rtype", OP_RTYPE, 0, 0);
    run_instr("lw_wait", OP_LW, 0, 3);
    run_instr("addi", OP_ADDI, 0, 0);
    run_instr("sw_wait", OP_SW, 1, 1);
    run_instr("beq", OP_BEQ, 0, 0);
    run_instr("j", OP_J, 0, 0);
    run_instr("illegal", OP_BAD, 0, 0);
    run_instr("lw", OP_LW, 2, 0);
    run_instr("sw", OP_SW, 0, 0);

    // Reset asserted while the load is writing back.
    Opcode = OP_LW;
    step("lwrst", B_FETCH, 1'b1);
    step("lwrst", B_DECODE, 1'b1);
    step("lwrst", B_MEMADR, 1'b1);
    step("lwrst", B_MEMRD, 1'b1);
    @(posedge clk);
    #1;
    check("memwb_regwrite", {31'd0, RegWrite}, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {14'd0, outv}, 0);
    @(negedge clk);
    check("rst_async_hold", {14'd0, outv}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release2", {14'd0, outv}, 0);

    run_instr("j_after_rst", OP_J, 0, 0);
    run_instr("rtype2", OP_RTYPE, 1, 0);

    @(posedge clk);
    @(negedge clk);
    check("lat_drain", lat_q.size(), 0);
    check("exp_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives every datapath select and enable, including RegDst for the write-register mux.
- Sits between the instruction register's opcode field and the datapath muxes and enables; waits on a memory-ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  Instruction[31:26] from the instruction register
- MemReady  input  1  memory completes current read/write this cycle
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IorD  output  1  0 = PC address, 1 = ALUOut address
- IRWrite  output  1  load instruction register
- PCWrite  output  1  unconditional PC load
- Branch  output  1  PC load qualified by ALU Zero (gated in datapath)
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- RegDst  output  1  0 = Instruction[20:16], 1 = Instruction[15:11]
- MemtoReg  output  1  0 = ALUOut, 1 = memory data register
- RegWrite  output  1  register file write enable
- InstrDone  output  1  one-cycle pulse in the final cycle of each instruction
- IllegalOp  output  1  one-cycle pulse on an undecoded opcode

Behaviour:
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ILLEGAL.
- Reset: rst_n low forces RST asynchronously. In RST every output is 0. The first rising edge after release goes to FETCH.
- Outputs are decoded combinationally from the state register. Only FETCH, MEMRD and MEMWR also depend on MemReady. Any output not listed for a state is 0.
- FETCH:
  - Always: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=MemReady.
  - Stay while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: LW -> MEMRD, SW -> MEMWR. Opcode is stable from IR.
- MEMRD: MemRead=1, IorD=1. Wait for MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for MemReady. InstrDone=MemReady; on MemReady go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, InstrDone=1. Next FETCH.
- JUMP: PCSrc=10, PCWrite=1, InstrDone=1. Next FETCH.
- ILLEGAL: IllegalOp=1, InstrDone=1, no writes. Next FETCH.
- Latency in cycles, MemReady always 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 3
- Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Invariants:
  - RegWrite, MemWrite and PCWrite never assert in the same cycle.
  - At most one of MemRead/MemWrite is high.
- Reset mid-instruction: all outputs drop to 0 immediately (asynchronous). No partial write may follow; restart at FETCH.
- Unreachable state encodings fall through to FETCH.

Test Plan:
- Reset: hold rst_n=0 two cycles, release -> all outputs 0 during reset. The next cycle is FETCH with MemRead=1, ALUSrcB=01.
- R-type, Opcode=000000, MemReady=1 -> FETCH, DECODE, EXEC (ALUOp=10), ALUWB (RegDst=1, RegWrite=1, InstrDone=1). Back in FETCH on cycle 5.
- lw, Opcode=100011, MemReady low 3 cycles in MEMRD -> stays in MEMRD 4 cycles. MEMWB then shows RegDst=0, MemtoReg=1, RegWrite=1. Total 8 cycles.
- addi then sw:
  - addi reaches ADDIWB with RegDst=0, RegWrite=1.
  - sw reaches MEMWR with MemWrite=1, IorD=1, and never RegWrite.
- beq then j:
  - BRANCH shows Branch=1, PCSrc=01, ALUOp=01.
  - JUMP shows PCWrite=1, PCSrc=10.
  - Each takes 3 cycles.
- Opcode=111111 -> IllegalOp and InstrDone pulse for 1 cycle in cycle 3, no enables, then FETCH. Separately, assert rst_n=0 in MEMWB -> RegWrite falls the same cycle.
